decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the five-stage MIPS pipeline, sitting between fetch and execute. It consumes the 64-bit IF/ID word, decodes the opcode into WB/M/EX control fields, and reads two operands from an internal 32x32 register file that is written by the writeback stage. It produces the 147-bit ID/EX pipeline register in the exact layout the execute stage unpacks. It also detects load-use hazards, requesting a fetch stall and inserting a bubble, and it inserts a bubble on a taken-branch flush.

## Interface
Parameters: none; all widths are fixed by the ID/EX layout.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_id  in  64  [31:0] instruction, [63:32] incremented PC.
- wb_reg_write  in  1  register file write enable from writeback (WB[0] of MEM/WB).
- wb_rd  in  5  destination register from writeback.
- wb_data  in  32  write data from writeback.
- flush  in  1  PCSrc from memory stage; the instruction currently in decode is discarded.
- id_ex  out  147  registered ID/EX word:
  - [1:0] WB: [1] MemtoReg, [0] RegWrite.
  - [4:2] M: [4] Branch, [3] MemRead, [2] MemWrite.
  - [8:5] EX: [8:7] ALUOp, [6] RegDst, [5] ALUSrc.
  - [40:9] incPC, [72:41] rs data, [104:73] rt data, [136:105] sign-extended imm, [141:137] rt, [146:142] rd.
- stall  out  1  combinational; when high, fetch holds PC and IF/ID.

## Operation
- Fields: opcode=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]. Sign extension replicates imm[15] into bits [31:16].
- Control per opcode, listed as {MemtoReg,RegWrite | Branch,MemRead,MemWrite | ALUOp,RegDst,ALUSrc}:
  - R-type 0x00: 01|000|10,1,0.
  - lw 0x23: 11|010|00,0,1.
  - sw 0x2B: 00|001|00,0,1.
  - beq 0x04: 00|100|01,0,0.
  - addi 0x08: 01|000|00,0,1.
  - Any other opcode: all control zero (treated as a NOP).
- Register file: 32 entries of 32 bits. Register 0 reads as 0, and writes to it are ignored. Write happens at posedge when wb_reg_write=1.
- Read bypass: if wb_reg_write=1, wb_rd=rs (or rt), and wb_rd!=0, the read returns wb_data in the same cycle.
- Load-use hazard:
  - Hazard condition: id_ex[3]=1, and id_ex[141:137]!=0, and it equals rs, or equals rt when the decoded op is R-type, sw or beq.
  - stall = hazard & ~flush.
- Next id_ex at posedge:
  - If flush or hazard: control fields [8:0] are loaded as zero (bubble); data fields load normally but are don't-care.
  - Otherwise: the full decoded word is loaded.
- Flush has priority over the stall.

## Timing
- Reset, asynchronous: id_ex=0 and all 32 registers=0. stall=0 while rst_n=0 because id_ex[3]=0.
- Latency: an instruction presented on if_id at cycle N appears on id_ex after posedge N+1 (one cycle).
- A register written at posedge T is visible to a decode occurring in the cycle ending at T, via the bypass, and in every later cycle.
- Stall lasts exactly one cycle per load-use pair. The bubble clears id_ex[3], which drops stall in the next cycle, while fetch holds the same instruction.
- Reset asserted mid-operation clears id_ex and the register file immediately, without waiting for clk.
- Simultaneous flush and hazard: a bubble is inserted and stall=0.

## Test plan
- Reset then R-type: write r1=5 and r2=7 through the wb port, then present add r3,r1,r2 (0x00221820) with incPC=0x8. Next edge: id_ex WB=01, M=000, EX=1010, rs data=5, rt data=7, rt=2, rd=3, incPC=8.
- Bypass: in the same cycle, wb writes r4=0xDEAD while decode presents sw r4,12(r0). Expected: rt data=0xDEAD, imm=12, M=001, EX=0001.
- Sign extension: addi r5,r0,-4 (0x2005FFFC). Expected: imm field=0xFFFFFFFC, rs data=0.
- Load-use: lw r6,0(r0) followed by add r7,r6,r6. Expected: stall=1 for one cycle, then id_ex control=0, then the add issues with stall=0.
- Flush: assert flush during the stall cycle of the load-use case. Expected: stall=0 and id_ex control=0. Separately, verify that a write to r0 leaves r0 reading as 0.
- Async reset mid-stream: drop rst_n between edges. Expected: id_ex=0 immediately and stall=0; all registers read 0 after release.

Source files
------------

// File: rtl/decode_stage_if.sv
// Signal bundle between the decode stage and its neighbours: the IF/ID word,
// the writeback port, the branch flush, the ID/EX word and the fetch stall.
interface decode_stage_if;
  logic [63:0]  if_id;
  logic         wb_reg_write;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic         flush;
  logic [146:0] id_ex;
  logic         stall;

  modport master (
    output if_id, wb_reg_write, wb_rd, wb_data, flush,
    input  id_ex, stall
  );

  modport slave (
    input  if_id, wb_reg_write, wb_rd, wb_data, flush,
    output id_ex, stall
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: control decode, 32x32 register file with
// writeback bypass, load-use hazard detection and ID/EX pipeline register.
module decode_stage (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Field order matches id_ex[8:0]: EX in the high bits, WB in the low bits.
  typedef struct packed {
    logic [3:0] ex;  // {ALUOp[1:0], RegDst, ALUSrc}
    logic [2:0] m;   // {Branch, MemRead, MemWrite}
    logic [1:0] wb;  // {MemtoReg, RegWrite}
  } ctrl_t;

  logic [31:0]  w_instr;
  logic [31:0]  w_inc_pc;
  logic [5:0]   w_opcode;
  logic [4:0]   w_rs;
  logic [4:0]   w_rt;
  logic [4:0]   w_rd;
  logic [31:0]  w_imm_ext;
  ctrl_t        w_ctrl;
  logic [8:0]   w_ctrl_out;
  logic         w_uses_rt;
  logic [31:0]  w_rs_data;
  logic [31:0]  w_rt_data;
  logic [4:0]   w_ex_rt;
  logic         w_ex_mem_read;
  logic         w_hazard;
  logic         w_bubble;

  logic [31:0]  r_regs [32];
  logic [146:0] r_id_ex;

  assign w_instr   = bus.if_id[31:0];
  assign w_inc_pc  = bus.if_id[63:32];
  assign w_opcode  = w_instr[31:26];
  assign w_rs      = w_instr[25:21];
  assign w_rt      = w_instr[20:16];
  assign w_rd      = w_instr[15:11];
  assign w_imm_ext = {{16{w_instr[15]}}, w_instr[15:0]};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_ctrl = '0;
    unique case (w_opcode)
      OP_RTYPE: w_ctrl = '{ex: 4'b1010, m: 3'b000, wb: 2'b01};
      OP_LW:    w_ctrl = '{ex: 4'b0001, m: 3'b010, wb: 2'b11};
      OP_SW:    w_ctrl = '{ex: 4'b0001, m: 3'b001, wb: 2'b00};
      OP_BEQ:   w_ctrl = '{ex: 4'b0100, m: 3'b100, wb: 2'b00};
      OP_ADDI:  w_ctrl = '{ex: 4'b0001, m: 3'b000, wb: 2'b01};
      default:  w_ctrl = '0;
    endcase
  end

  assign w_uses_rt = (w_opcode == OP_RTYPE) || (w_opcode == OP_SW) ||
                     (w_opcode == OP_BEQ);

  // Writeback data is forwarded so a same-cycle write is seen by this decode.
  always_comb begin
    w_rs_data = r_regs[w_rs];
    if (w_rs == 5'd0)
      w_rs_data = '0;
    else if (bus.wb_reg_write && (bus.wb_rd == w_rs))
      w_rs_data = bus.wb_data;
  end

  always_comb begin
    w_rt_data = r_regs[w_rt];
    if (w_rt == 5'd0)
      w_rt_data = '0;
    else if (bus.wb_reg_write && (bus.wb_rd == w_rt))
      w_rt_data = bus.wb_data;
  end

  assign w_ex_rt       = r_id_ex[141:137];
  assign w_ex_mem_read = r_id_ex[3];
  assign w_hazard      = w_ex_mem_read && (w_ex_rt != 5'd0) &&
                         ((w_ex_rt == w_rs) || (w_uses_rt && (w_ex_rt == w_rt)));
  assign w_bubble      = bus.flush || w_hazard;
  assign w_ctrl_out    = w_bubble ? 9'd0 : w_ctrl;

  // NOTE: the register file is cleared by reset because the pipeline relies
  // on every register reading 0 afterwards, not just r0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (bus.wb_reg_write && (bus.wb_rd != 5'd0)) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_id_ex <= '0;
    else
      r_id_ex <= {w_rd, w_rt, w_imm_ext, w_rt_data, w_rs_data, w_inc_pc, w_ctrl_out};
  end

  assign bus.id_ex = r_id_ex;
  assign bus.stall = w_hazard && !bus.flush;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised scoreboard bench for decode_stage: a driver runs a reference
// model and queues expectations; a monitor compares them each cycle.
module tb_decode_stage;

  typedef struct {
    logic [146:0] id_ex;
    bit           ctrl_only;
    bit           stall;
  } exp_t;

  localparam logic [31:0]  NOP       = 32'hFC00_0000;
  localparam logic [146:0] MASK_ALL  = {147{1'b1}};
  localparam logic [146:0] MASK_CTRL = 147'h1FF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0]  m_regs [32];
  logic [146:0] m_idex, m_next;
  bit           m_idex_dc, m_next_dc;
  exp_t         sb [$];

  task automatic check(input string name, input logic [146:0] act,
                       input logic [146:0] exp, input logic [146:0] mask);
    tests++;
    if ((act & mask) !== (exp & mask)) begin
      fails++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, mask);
    end
  endtask

  // Control words straight from the opcode table, as {EX, M, WB}.
  function automatic logic [8:0] ctrl_of(input logic [5:0] opc);
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
    case (opc)
      6'h00:   begin wb = 2'b01; m = 3'b000; ex = 4'b1010; end
      6'h23:   begin wb = 2'b11; m = 3'b010; ex = 4'b0001; end
      6'h2B:   begin wb = 2'b00; m = 3'b001; ex = 4'b0001; end
      6'h04:   begin wb = 2'b00; m = 3'b100; ex = 4'b0100; end
      6'h08:   begin wb = 2'b01; m = 3'b000; ex = 4'b0001; end
      default: begin wb = 2'b00; m = 3'b000; ex = 4'b0000; end
    endcase
    return {ex, m, wb};
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] r, input bit wbw,
                                           input logic [4:0] wbrd, input logic [31:0] wbd);
    if (r == 5'd0) return 32'd0;
    if (wbw && (wbrd == r)) return wbd;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_idex = '0; m_next = '0; m_idex_dc = 1'b0; m_next_dc = 1'b0;
  endtask

  // One pipeline cycle: drive inputs after the edge, queue what the monitor
  // must see at the following falling edge, then advance the model.
  task automatic step(input logic [31:0] instr, input logic [31:0] pc, input bit wbw,
                      input logic [4:0] wbrd, input logic [31:0] wbd, input bit fl,
                      output bit stl);
    exp_t        e;
    logic [5:0]  opc;
    logic [4:0]  rs, rt, rd, ex_rt;
    bit          uses_rt, hazard;
    @(posedge clk);
    m_idex    = m_next;
    m_idex_dc = m_next_dc;
    #2;
    rst_n            = 1'b1;
    bus.if_id        = {pc, instr};
    bus.wb_reg_write = wbw;
    bus.wb_rd        = wbrd;
    bus.wb_data      = wbd;
    bus.flush        = fl;
    opc = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
    uses_rt = (opc == 6'h00) || (opc == 6'h2B) || (opc == 6'h04);
    ex_rt   = m_idex[141:137];
    hazard  = m_idex[3] && (ex_rt != 5'd0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    stl     = hazard && !fl;
    e.id_ex = m_idex; e.ctrl_only = m_idex_dc; e.stall = stl;
    sb.push_back(e);
    m_next_dc = fl || hazard;
    m_next = {rd, rt, {{16{instr[15]}}, instr[15:0]},
              read_reg(rt, wbw, wbrd, wbd), read_reg(rs, wbw, wbrd, wbd), pc,
              m_next_dc ? 9'd0 : ctrl_of(opc)};
    if (wbw && (wbrd != 5'd0)) m_regs[wbrd] = wbd;
  endtask

  task automatic idle(input bit wbw, input logic [4:0] wbrd, input logic [31:0] wbd);
    bit s;
    step(NOP, 32'h0, wbw, wbrd, wbd, 1'b0, s);
  endtask

  // Presents an instruction, holding it while the stall is expected.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    bit s;
    int n = 0;
    do begin
      step(instr, pc, 1'b0, 5'd0, 32'd0, 1'b0, s);
      n++;
    end while (s && n < 3);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    bus.wb_reg_write = 1'b0;
    bus.flush        = 1'b0;
    rst_n            = 1'b0;
    #1;
    check("reset_id_ex", bus.id_ex, '0, MASK_ALL);
    check("reset_stall", {146'd0, bus.stall}, '0, MASK_ALL);
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("id_ex", bus.id_ex, e.id_ex, e.ctrl_only ? MASK_CTRL : MASK_ALL);
        check("stall", {146'd0, bus.stall}, {146'd0, e.stall}, MASK_ALL);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : driver
    bit          s;
    logic [31:0] cur;
    logic [5:0]  opc;
    logic [2:0]  pick;
    rst_n            = 1'b0;
    bus.if_id        = {32'h0, NOP};
    bus.wb_reg_write = 1'b0;
    bus.wb_rd        = 5'd0;
    bus.wb_data      = 32'd0;
    bus.flush        = 1'b0;
    model_reset();
    #3;
    check("init_id_ex", bus.id_ex, '0, MASK_ALL);
    check("init_stall", {146'd0, bus.stall}, '0, MASK_ALL);

    // add r3,r1,r2 after writing r1=5, r2=7
    idle(1'b1, 5'd1, 32'd5);
    idle(1'b1, 5'd2, 32'd7);
    issue(32'h0022_1820, 32'h8);
    // sw r4,12(r0) with r4 written in the same cycle
    step(32'hAC04_000C, 32'hC, 1'b1, 5'd4, 32'hDEAD, 1'b0, s);
    // addi r5,r0,-4
    issue(32'h2005_FFFC, 32'h10);
    // lw r6 then dependent add: one stall, one bubble
    issue(32'h8C06_0000, 32'h14);
    issue(32'h00C6_3820, 32'h18);
    // lw r6 then dependent add with flush during the would-be stall
    issue(32'h8C06_0000, 32'h1C);
    step(32'h00C6_3820, 32'h20, 1'b0, 5'd0, 32'd0, 1'b1, s);
    issue(32'h00C6_3820, 32'h20);
    // write to r0 is ignored, also on the bypass path
    idle(1'b1, 5'd0, 32'h1234);
    step(32'h0000_4020, 32'h24, 1'b1, 5'd0, 32'h5678, 1'b0, s);
    idle(1'b0, 5'd0, 32'd0);

    cur = NOP;
    for (int i = 0; i < 400; i++) begin
      step(cur, 32'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           32'($urandom), ($urandom_range(0, 9) == 0), s);
      if (!s) begin
        pick = 3'($urandom_range(0, 5));
        case (pick)
          3'd0:    opc = 6'h00;
          3'd1:    opc = 6'h23;
          3'd2:    opc = 6'h2B;
          3'd3:    opc = 6'h04;
          3'd4:    opc = 6'h08;
          default: opc = 6'($urandom);
        endcase
        cur = {opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom), 11'($urandom)};
      end
    end

    async_reset();
    for (int i = 0; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      issue({6'h00, r, r, 5'd9, 11'h020}, 32'(i));
    end
    idle(1'b0, 5'd0, 32'd0);
    idle(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
